// File: rtl/ft601_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ft601_pkg
//  Purpose  : Shared constants and types for the FT601 transmit engine.
//             Holds the FSM state encoding, byte-enable constant and
//             default widths used by ft601_tx_fsm and ft601_skid_buf.
//  Revision : 1.0 - initial release
// ============================================================================
package ft601_pkg;

    localparam int c_DATA_LEN_DEF = 32;
    localparam int c_CNT_LEN_DEF  = 32;
    localparam int c_BE_W         = 4;

    // All four byte lanes valid on every FT601 write.
    localparam logic [c_BE_W-1:0] BE_ALL = 4'hF;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BURST = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_BURST = c_ST_BURST,
        ST_GAP   = c_ST_GAP,
        ST_DRAIN = c_ST_DRAIN
    } ft_state_t;

endpackage : ft601_pkg
`default_nettype wire

// File: rtl/ft601_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module   : ft601_skid_buf
//  Purpose  : Small register FIFO used as the prefetch/skid buffer between
//             the capture FIFO read port and the FT601 bus.
//  Ports    : clk, rst_n      - clock, async active-low reset
//             push, push_data - write one entry at the tail
//             pop             - drop the head entry
//             head            - current head entry (zero after reset)
//             count           - current occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module ft601_skid_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0] w_wr_ptr_inc;
    logic [c_PTR_W-1:0] w_rd_ptr_inc;

    // Explicit wrap so DEPTH need not be a power of two.
    always_comb begin
        w_wr_ptr_inc = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_inc = (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= w_wr_ptr_inc;
            end
            if (pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule : ft601_skid_buf
`default_nettype wire

// File: rtl/ft601_tx_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : ft601_tx_fsm
//  Purpose  : FT601 245-sync-FIFO transmit engine. Prefetches words from the
//             capture FIFO into a skid buffer and drives FT601 write bursts,
//             throttled by txe_n, with a one-cycle gap every MAX_BURST words.
//  Ports    : clk, rst_n            - FT601 clock, async active-low reset
//             tx_en                 - streaming enable
//             fifo_empty, fifo_data - capture FIFO read side
//             fifo_rd_en_n          - FIFO pop request (active low, comb.)
//             txe_n                 - FT601 not-ready flag
//             ft_wr_n, ft_data_out, ft_data_oe, ft_be - FT601 bus
//             tx_count              - words accepted by the FT601
//             busy                  - engine not idle
//  Revision : 1.0 - initial release
// ============================================================================
module ft601_tx_fsm
    import ft601_pkg::*;
#(
    parameter int DATA_LEN   = c_DATA_LEN_DEF,
    parameter int RD_LATENCY = 1,
    parameter int SKID_DEPTH = 4,
    parameter int MAX_BURST  = 256,
    parameter int CNT_LEN    = c_CNT_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tx_en,
    input  logic                fifo_empty,
    input  logic [DATA_LEN-1:0] fifo_data,
    output logic                fifo_rd_en_n,
    input  logic                txe_n,
    output logic                ft_wr_n,
    output logic [DATA_LEN-1:0] ft_data_out,
    output logic                ft_data_oe,
    output logic [c_BE_W-1:0]   ft_be,
    output logic [CNT_LEN-1:0]  tx_count,
    output logic                busy
);

    localparam int c_OCC_W = $clog2(SKID_DEPTH + 1);
    localparam int c_SUM_W = c_OCC_W + 2;
    localparam int c_BC_W  = $clog2(MAX_BURST + 1);
    localparam logic [c_BC_W-1:0] c_MAX_BC = c_BC_W'(MAX_BURST);

    ft_state_t           r_state;
    ft_state_t           w_state_next;
    logic                r_wr_n;
    logic                w_wr_n_next;
    logic [CNT_LEN-1:0]  r_tx_count;
    logic [c_BC_W-1:0]   r_burst_cnt;
    logic [c_BC_W-1:0]   w_bc_next;
    logic                w_bc_clr;
    logic [RD_LATENCY-1:0] r_pipe;

    logic                w_xfer;
    logic                w_stall;
    logic                w_push;
    logic                w_pop;
    logic                w_room;
    logic [c_OCC_W-1:0]  w_occ;
    logic [c_OCC_W-1:0]  w_occ_after;
    logic [c_OCC_W-1:0]  w_occ_next;
    logic [c_OCC_W-1:0]  w_inflight;
    logic [c_OCC_W-1:0]  w_infl_next;
    logic [DATA_LEN-1:0] w_head;

    // A word leaves only when the strobe is low and the FT601 is ready.
    assign w_xfer  = ~r_wr_n & ~txe_n;
    // Strobe asserted but the FT601 refused: hold everything in place.
    assign w_stall = ~r_wr_n &  txe_n;
    assign w_push  = r_pipe[RD_LATENCY-1];

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + c_OCC_W'(r_pipe[i]);
        end
    end

    // Reserve a skid slot for every outstanding read so a pop can never
    // overflow the buffer, whatever txe_n does afterwards.
    assign w_occ_after = w_occ - c_OCC_W'(w_xfer);
    assign w_room      = (c_SUM_W'(w_occ_after) + c_SUM_W'(w_inflight) + c_SUM_W'(1))
                         <= c_SUM_W'(SKID_DEPTH);
    assign w_pop       = (r_state == ST_BURST) & tx_en & ~fifo_empty & ~w_stall & w_room;

    assign w_occ_next  = w_occ_after + c_OCC_W'(w_push);
    assign w_infl_next = w_inflight - c_OCC_W'(w_push) + c_OCC_W'(w_pop);
    assign w_bc_next   = r_burst_cnt + c_BC_W'(w_xfer);

    ft601_skid_buf #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (DATA_LEN),
        .CNT_W (c_OCC_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (fifo_data),
        .pop       (w_xfer),
        .head      (w_head),
        .count     (w_occ)
    );

    always_comb begin
        w_state_next = r_state;
        w_wr_n_next  = 1'b1;
        w_bc_clr     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_bc_clr = 1'b1;
                if (tx_en && !txe_n && !fifo_empty) begin
                    w_state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                w_wr_n_next = !((w_occ_next != '0) && (w_bc_next < c_MAX_BC));
                if (w_bc_next == c_MAX_BC) begin
                    w_state_next = ST_GAP;
                end else if (!tx_en) begin
                    w_state_next = ST_DRAIN;
                end else if (fifo_empty && (w_occ_next == '0) && (w_infl_next == '0)) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                // Strobe is already high this cycle; counter restarts here.
                w_bc_clr     = 1'b1;
                w_wr_n_next  = (w_occ_next == '0);
                w_state_next = ST_BURST;
            end
            ST_DRAIN: begin
                w_wr_n_next = !((w_occ_next != '0) && (w_bc_next < c_MAX_BC));
                if (w_bc_next == c_MAX_BC) begin
                    w_state_next = ST_GAP;
                end else if ((w_occ_next == '0) && (w_infl_next == '0)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wr_n      <= 1'b1;
            r_tx_count  <= '0;
            r_burst_cnt <= '0;
            r_pipe      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wr_n      <= w_wr_n_next;
            r_tx_count  <= r_tx_count + CNT_LEN'(w_xfer);
            r_burst_cnt <= w_bc_clr ? '0 : w_bc_next;
            r_pipe[0]   <= w_pop;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign fifo_rd_en_n = ~w_pop;
    assign ft_wr_n      = r_wr_n;
    assign ft_data_out  = w_head;
    assign ft_be        = r_wr_n ? '0 : BE_ALL;
    assign ft_data_oe   = (r_state != ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign tx_count     = r_tx_count;

endmodule : ft601_tx_fsm
`default_nettype wire

// File: tb/tb_ft601_tx_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ft601_tx_fsm
//  Purpose  : Self-checking bench for ft601_tx_fsm (MAX_BURST=4). A FIFO
//             model feeds the DUT, a receiver model logs accepted words and
//             every delivered word is compared in order against the words
//             written into the FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ft601_tx_fsm;

    localparam int MAXB  = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tx_en = 1'b0;
    logic        fifo_empty;
    logic [31:0] fifo_data = '0;
    logic        fifo_rd_en_n;
    logic        txe_n = 1'b1;
    logic        ft_wr_n;
    logic [31:0] ft_data_out;
    logic        ft_data_oe;
    logic [3:0]  ft_be;
    logic [31:0] tx_count;
    logic        busy;

    ft601_tx_fsm #(.MAX_BURST(MAXB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_en        (tx_en),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_rd_en_n (fifo_rd_en_n),
        .txe_n        (txe_n),
        .ft_wr_n      (ft_wr_n),
        .ft_data_out  (ft_data_out),
        .ft_data_oe   (ft_data_oe),
        .ft_be        (ft_be),
        .tx_count     (tx_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // ---------------- capture FIFO model (read latency 1) ----------------
    logic [31:0] fifo_mem [0:1023];
    int          wr_total = 0;
    int          rd_total = 0;
    bit          pop_pending = 1'b0;
    assign fifo_empty = (wr_total == rd_total);

    always @(negedge clk) pop_pending <= !fifo_rd_en_n && !fifo_empty;
    always @(posedge clk) begin
        if (!rst_n) begin
            rd_total <= wr_total;
        end else if (pop_pending) begin
            fifo_data <= fifo_mem[rd_total % 1024];
            rd_total  <= rd_total + 1;
        end
    end

    // ---------------- receiver / bus monitor ----------------
    logic [31:0] rx_mem [0:1023];
    bit          wrn_log [0:4095];
    int rx_n = 0, pop_n = 0, pop_dis = 0, wr_low_n = 0;
    int run_len = 0, run_viol = 0, hold_viol = 0, max_pre = 0, cyc = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            run_len    = 0;
        end else begin
            if (cyc < 4096) wrn_log[cyc] = ft_wr_n;
            cyc++;
            if (prev_stall && (ft_wr_n || ft_data_out !== prev_data)) hold_viol++;
            prev_stall = !ft_wr_n && txe_n;
            prev_data  = ft_data_out;
            if (!ft_wr_n) wr_low_n++;
            if (!ft_wr_n && !txe_n) begin
                rx_mem[rx_n % 1024] = ft_data_out;
                rx_n++;
                run_len++;
                if (run_len > MAXB) run_viol++;
            end
            if (ft_wr_n) run_len = 0;
            if (!fifo_rd_en_n && !fifo_empty) begin
                pop_n++;
                if (!tx_en) pop_dis++;
            end
            if (pop_n - rx_n > max_pre) max_pre = pop_n - rx_n;
        end
    end

    // ---------------- checking helpers ----------------
    int          errors = 0;
    int          checks = 0;
    int          rx_chk = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] v);
        fifo_mem[wr_total % 1024] = v;
        wr_total++;
        exp_q.push_back(v);
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] got;
        logic [31:0] e;
        while (rx_chk < rx_n) begin
            got = rx_mem[rx_chk % 1024];
            e   = (exp_q.size() > 0) ? exp_q.pop_front() : ~got;
            chk(tag, got, e);
            rx_chk++;
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed=timeout expected=event", tag);
    endtask

    task automatic run_until_idle(input string tag, input int budget, input bit rand_txe);
        bit seen = 1'b0;
        int n;
        for (n = 0; n < budget; n++) begin
            @(posedge clk); #2;
            if (rand_txe) txe_n = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (busy) seen = 1'b1;
            else if (seen) break;
        end
        if (n >= budget) timeout_fail(tag);
        @(posedge clk); #2;
        txe_n = 1'b0;
    endtask

    // ---------------- directed / random sequence ----------------
    initial begin
        int          rx_base, pop_base, wl_base, lb, first, n;
        logic [31:0] hold0;
        logic [31:0] held [3];
        logic        heldw [3];
        bit          pat [12];

        // Reset values
        #1 rst_n = 1'b0;
        #11;
        chk("rst_wr_n", ft_wr_n, 1);
        chk("rst_oe", ft_data_oe, 0);
        chk("rst_be", ft_be, 0);
        chk("rst_data", ft_data_out, 0);
        chk("rst_count", tx_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en_n", fifo_rd_en_n, 1);
        @(posedge clk); #2 rst_n = 1'b1;

        // Steady stream of 10 words
        rx_base = rx_n; pop_base = pop_n;
        for (int i = 1; i <= 10; i++) push_word(32'(i));
        tx_en = 1'b1; txe_n = 1'b0;
        run_until_idle("steady_idle", 200, 1'b0);
        check_rx("steady_word");
        chk("steady_words", rx_n - rx_base, 10);
        chk("steady_pops", pop_n - pop_base, 10);
        chk("steady_count", tx_count, rx_n);
        chk("steady_busy", busy, 0);

        // Backpressure: 3 stalled cycles while the strobe is low
        rx_base = rx_n;
        for (int i = 0; i < 12; i++) push_word($urandom);
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (!(!ft_wr_n && rx_n > rx_base) && n < 100);
        if (n >= 100) timeout_fail("bp_start");
        txe_n = 1'b1;
        hold0 = ft_data_out;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            held[i]  = ft_data_out;
            heldw[i] = ft_wr_n;
        end
        txe_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_data", held[i], hold0);
            chk("bp_hold_wr_n", heldw[i], 0);
        end
        run_until_idle("bp_idle", 200, 1'b0);
        check_rx("bp_word");
        chk("bp_words", rx_n - rx_base, 12);
        chk("bp_hold_viol", hold_viol, 0);

        // Burst gap with MAX_BURST=4 and 9 words
        lb = cyc;
        for (int i = 0; i < 9; i++) push_word(32'h100 + 32'(i));
        run_until_idle("gap_idle", 200, 1'b0);
        check_rx("gap_word");
        n = 0;
        for (int w = 1; w <= 9; w++) begin
            pat[n++] = 1'b0;
            if (w % MAXB == 0) pat[n++] = 1'b1;
        end
        pat[n] = 1'b1;
        first = lb;
        while (first < cyc && wrn_log[first]) first++;
        for (int j = 0; j < 12; j++) chk("gap_wr_n_pattern", wrn_log[first + j], pat[j]);

        // Drain: tx_en falls mid-burst with prefetched words outstanding
        rx_base = rx_n; pop_base = pop_n;
        wl_base = pop_dis;
        for (int i = 0; i < 20; i++) push_word($urandom);
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (!(!ft_wr_n && rx_n >= rx_base + 2) && n < 100);
        if (n >= 100) timeout_fail("drain_start");
        tx_en = 1'b0;
        txe_n = 1'b1;
        run_until_idle("drain_idle", 500, 1'b1);
        check_rx("drain_word");
        chk("drain_all_prefetched_sent", rx_n - rx_base, pop_n - pop_base);
        chk("drain_no_pops", pop_dis - wl_base, 0);
        chk("drain_left_in_fifo", (wr_total - rd_total) > 0, 1);
        chk("drain_busy", busy, 0);

        // Random throttling, flushes the drain leftovers too
        for (int i = 0; i < 30; i++) push_word($urandom);
        tx_en = 1'b1;
        run_until_idle("rand_idle", 3000, 1'b1);
        check_rx("rand_word");
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_fifo_empty", fifo_empty, 1);
        chk("rand_count", tx_count, rx_n);
        chk("rand_burst_limit", run_viol, 0);
        chk("rand_hold_viol", hold_viol, 0);
        chk("max_prefetch_ok", max_pre <= DEPTH, 1);

        // Single word
        rx_base = rx_n; wl_base = wr_low_n;
        push_word(32'hCAFE_0001);
        run_until_idle("single_idle", 100, 1'b0);
        check_rx("single_word");
        chk("single_words", rx_n - rx_base, 1);
        chk("single_wr_low_cycles", wr_low_n - wl_base, 1);
        chk("single_busy", busy, 0);

        // Asynchronous reset in the middle of a burst
        rx_base = rx_n;
        for (int i = 0; i < 20; i++) push_word($urandom);
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (!(rx_n >= rx_base + 3 && !ft_wr_n) && n < 100);
        if (n >= 100) timeout_fail("arst_start");
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_n", ft_wr_n, 1);
        chk("arst_oe", ft_data_oe, 0);
        chk("arst_count", tx_count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_be", ft_be, 0);
        chk("arst_rd_en_n", fifo_rd_en_n, 1);
        tx_en = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #2;
        chk("arst_after_count", tx_count, 0);
        chk("arst_after_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ft601_tx_fsm
`default_nettype wire
